// File: rtl/psum_collector_pkg.sv
// Shared types and helpers for the systolic-array psum collector.
package psum_collector_pkg;

   localparam int PSUM_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN
   } state_e;

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/psum_deskew.sv
// Triangular delay: lane c gets ARRAY_SIZE-1-c stages so all lanes line up
// with a valid delayed by ARRAY_SIZE-1 stages.
module psum_deskew
   import psum_collector_pkg::*;
#(
   parameter int ARRAY_SIZE = 8,
   parameter int PSUM_W     = PSUM_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_i,
   input  logic [ARRAY_SIZE*PSUM_W-1:0] data_i,
   output logic                         valid_o,
   output logic [ARRAY_SIZE*PSUM_W-1:0] data_o
);

   localparam int VD = ARRAY_SIZE - 1;

   for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
      localparam int D = ARRAY_SIZE - 1 - c;
      if (D == 0) begin : g_thru
         assign data_o[lane_lsb(c, PSUM_W) +: PSUM_W] =
            data_i[lane_lsb(c, PSUM_W) +: PSUM_W];
      end else begin : g_pipe
         logic [PSUM_W-1:0] pipe_q [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < D; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= data_i[lane_lsb(c, PSUM_W) +: PSUM_W];
               for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign data_o[lane_lsb(c, PSUM_W) +: PSUM_W] = pipe_q[D-1];
      end
   end

   if (VD == 0) begin : g_vthru
      assign valid_o = valid_i;
   end else begin : g_vpipe
      logic vpipe_q [VD];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < VD; i++) vpipe_q[i] <= 1'b0;
         end else begin
            vpipe_q[0] <= valid_i;
            for (int i = 1; i < VD; i++) vpipe_q[i] <= vpipe_q[i-1];
         end
      end
      assign valid_o = vpipe_q[VD-1];
   end

endmodule

// File: rtl/psum_collector.sv
// De-skews array psums, accumulates them over K-passes into a row bank,
// then drains the finished tile over a valid/ready stream.
module psum_collector
   import psum_collector_pkg::*;
#(
   parameter int ARRAY_SIZE = 8,
   parameter int PSUM_W     = PSUM_W_DEF,
   parameter int ACC_DEPTH  = 16,
   localparam int AW        = $clog2(ACC_DEPTH),
   localparam int VW        = ARRAY_SIZE * PSUM_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] tile_rows_m1,
   input  logic [7:0]    num_passes_m1,
   input  logic          psum_valid,
   input  logic [VW-1:0] psums_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] out_data,
   output logic [AW-1:0] out_row,
   output logic          busy,
   output logic          done,
   output logic          err_overrun
);

   logic          al_valid;
   logic [VW-1:0] al_data;

   psum_deskew #(
      .ARRAY_SIZE(ARRAY_SIZE),
      .PSUM_W    (PSUM_W)
   ) u_deskew (
      .clk    (clk),
      .rst    (rst),
      .valid_i(psum_valid),
      .data_i (psums_in),
      .valid_o(al_valid),
      .data_o (al_data)
   );

   state_e        state_q, state_d;
   logic [AW-1:0] rows_q, rows_d;
   logic [7:0]    passes_q, passes_d;
   logic [AW-1:0] row_ptr_q, row_ptr_d;
   logic [7:0]    pass_cnt_q, pass_cnt_d;
   logic [AW-1:0] drain_ptr_q, drain_ptr_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic          ovalid_q, ovalid_d;
   logic [VW-1:0] odata_q, odata_d;
   logic [AW-1:0] orow_q, orow_d;

   logic [VW-1:0] acc_q [ACC_DEPTH];
   logic [VW-1:0] acc_wr;
   logic          acc_we;
   logic [AW-1:0] drain_nxt;

   assign drain_nxt = drain_ptr_q + AW'(1);

   // Pass 0 overwrites, so the bank never needs clearing.
   always_comb begin
      acc_wr = '0;
      for (int c = 0; c < ARRAY_SIZE; c++) begin
         if (pass_cnt_q == 8'd0)
            acc_wr[lane_lsb(c, PSUM_W) +: PSUM_W] =
               al_data[lane_lsb(c, PSUM_W) +: PSUM_W];
         else
            acc_wr[lane_lsb(c, PSUM_W) +: PSUM_W] =
               acc_q[row_ptr_q][lane_lsb(c, PSUM_W) +: PSUM_W] +
               al_data[lane_lsb(c, PSUM_W) +: PSUM_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      passes_d    = passes_q;
      row_ptr_d   = row_ptr_q;
      pass_cnt_d  = pass_cnt_q;
      drain_ptr_d = drain_ptr_q;
      err_d       = err_q;
      done_d      = 1'b0;
      ovalid_d    = ovalid_q;
      odata_d     = odata_q;
      orow_d      = orow_q;
      acc_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               rows_d     = tile_rows_m1;
               passes_d   = num_passes_m1;
               row_ptr_d  = '0;
               pass_cnt_d = '0;
               err_d      = 1'b0;
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            if (al_valid) begin
               acc_we = 1'b1;
               if (row_ptr_q == rows_q) begin
                  row_ptr_d  = '0;
                  pass_cnt_d = pass_cnt_q + 8'd1;
                  if (pass_cnt_q == passes_q) begin
                     state_d     = DRAIN;
                     drain_ptr_d = '0;
                  end
               end else begin
                  row_ptr_d = row_ptr_q + AW'(1);
               end
            end
         end
         DRAIN: begin
            if (!ovalid_q) begin
               ovalid_d = 1'b1;
               odata_d  = acc_q[drain_ptr_q];
               orow_d   = drain_ptr_q;
            end else if (out_ready) begin
               if (drain_ptr_q == rows_q) begin
                  ovalid_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  drain_ptr_d = drain_nxt;
                  odata_d     = acc_q[drain_nxt];
                  orow_d      = drain_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Set after the start-clear so a same-cycle drop is still flagged.
      if (al_valid && state_q != ACCUM) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rows_q      <= '0;
         passes_q    <= '0;
         row_ptr_q   <= '0;
         pass_cnt_q  <= '0;
         drain_ptr_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         ovalid_q    <= 1'b0;
         odata_q     <= '0;
         orow_q      <= '0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         passes_q    <= passes_d;
         row_ptr_q   <= row_ptr_d;
         pass_cnt_q  <= pass_cnt_d;
         drain_ptr_q <= drain_ptr_d;
         err_q       <= err_d;
         done_q      <= done_d;
         ovalid_q    <= ovalid_d;
         odata_q     <= odata_d;
         orow_q      <= orow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_we) acc_q[row_ptr_q] <= acc_wr;
   end

   assign out_valid   = ovalid_q;
   assign out_data    = odata_q;
   assign out_row     = orow_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed, table-driven bench for psum_collector (4 lanes, 16-row bank).
module tb_psum_collector;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] tile_rows_m1 = '0;
   logic [7:0]    num_passes_m1 = '0;
   logic          psum_valid = 1'b0;
   logic [N*W-1:0] psums_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N*W-1:0] out_data;
   logic [AW-1:0] out_row;
   logic          busy;
   logic          done;
   logic          err_overrun;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [0:3][31:0] a;
      logic [0:3][31:0] b;
      logic [0:3][31:0] e;
   } vec_t;

   vec_t             tbl [4];
   logic [0:3][31:0] sv [16];
   logic [0:3][31:0] ex [16];

   psum_collector #(
      .ARRAY_SIZE(N),
      .PSUM_W    (W),
      .ACC_DEPTH (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .tile_rows_m1 (tile_rows_m1),
      .num_passes_m1(num_passes_m1),
      .psum_valid   (psum_valid),
      .psums_in     (psums_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_row      (out_row),
      .busy         (busy),
      .done         (done),
      .err_overrun  (err_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: act=%0h req=%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_tile(input int r, input int p);
      start         = 1'b1;
      tile_rows_m1  = AW'(r);
      num_passes_m1 = 8'(p);
      tick();
      start = 1'b0;
   endtask

   // Present sv[0..n-1] with column c skewed by c cycles.
   task automatic feed(input int n);
      logic [N*W-1:0] v;
      for (int k = 0; k < n + N - 1; k++) begin
         v = '0;
         for (int c = 0; c < N; c++) begin
            int idx;
            idx = k - c;
            if (idx >= 0 && idx < n) v[c*W +: W] = sv[idx][c];
         end
         psum_valid = (k < n);
         psums_in   = v;
         tick();
      end
      psum_valid = 1'b0;
      psums_in   = '0;
   endtask

   task automatic drain(input int n);
      int w;
      out_ready = 1'b1;
      for (int r = 0; r < n; r++) begin
         w = 0;
         while (!out_valid && w < 20) begin
            tick();
            w++;
         end
         chk($sformatf("row%0d valid", r), 64'(out_valid), 64'd1);
         chk($sformatf("row%0d idx", r), 64'(out_row), 64'(r));
         for (int c = 0; c < N; c++)
            chk($sformatf("row%0d lane%0d", r, c),
                64'(out_data[c*W +: W]), 64'(ex[r][c]));
         tick();
      end
      chk("done pulse", 64'(done), 64'd1);
      chk("valid after last", 64'(out_valid), 64'd0);
      chk("busy after last", 64'(busy), 64'd0);
      out_ready = 1'b0;
      tick();
      chk("done one cycle", 64'(done), 64'd0);
   endtask

   initial begin
      tbl[0].a = '{32'd1, 32'd2, 32'd3, 32'd4};
      tbl[0].b = '{32'd10, 32'd20, 32'd30, 32'd40};
      tbl[0].e = '{32'd11, 32'd22, 32'd33, 32'd44};
      tbl[1].a = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
      tbl[1].b = '{32'd2, 32'd0, 32'd0, 32'd0};
      tbl[1].e = '{32'd1, 32'd0, 32'd0, 32'd0};
      tbl[2].a = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd5};
      tbl[2].b = '{32'h8000_0000, 32'd1, 32'd3, 32'hFFFF_FFFB};
      tbl[2].e = '{32'd0, 32'h8000_0000, 32'd1, 32'd0};
      tbl[3].a = '{32'd100, 32'd200, 32'd300, 32'd400};
      tbl[3].b = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
      tbl[3].e = '{32'd0, 32'd100, 32'd200, 32'd300};

      // Reset state
      #2;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst err", 64'(err_overrun), 64'd0);
      chk("rst out_data", 64'(out_data[63:0]), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Single pass, single row
      start_tile(0, 0);
      chk("busy after start", 64'(busy), 64'd1);
      sv[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
      feed(1);
      chk("drain entry valid", 64'(out_valid), 64'd0);
      tick();
      chk("drain first valid", 64'(out_valid), 64'd1);
      ex[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
      drain(1);

      // Two-pass single-row table
      for (int t = 0; t < 4; t++) begin
         start_tile(0, 1);
         sv[0] = tbl[t].a;
         sv[1] = tbl[t].b;
         feed(2);
         ex[0] = tbl[t].e;
         drain(1);
      end

      // Three passes, two rows
      start_tile(1, 2);
      for (int p = 0; p < 3; p++)
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++)
               sv[2*p+r][c] = 32'(10*p + r);
      feed(6);
      for (int c = 0; c < N; c++) begin
         ex[0][c] = 32'd30;
         ex[1][c] = 32'd33;
      end
      drain(2);
      chk("3pass err", 64'(err_overrun), 64'd0);

      // Backpressure on a four-row tile
      start_tile(3, 0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < N; c++) begin
            sv[r][c] = 32'(100*r + c);
            ex[r][c] = 32'(100*r + c);
         end
      feed(4);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("bp%0d row", i), 64'(out_row), 64'd0);
         chk($sformatf("bp%0d lane3", i),
             64'(out_data[3*W +: W]), 64'd3);
         tick();
      end
      drain(4);

      // Overrun while idle
      psum_valid = 1'b1;
      psums_in   = {N{32'h55}};
      tick();
      psum_valid = 1'b0;
      psums_in   = '0;
      tick();
      tick();
      chk("ovr early", 64'(err_overrun), 64'd0);
      tick();
      chk("ovr set", 64'(err_overrun), 64'd1);
      tick();
      chk("ovr sticky", 64'(err_overrun), 64'd1);
      start_tile(0, 0);
      chk("ovr clear", 64'(err_overrun), 64'd0);
      sv[0] = '{32'd7, 32'd8, 32'd9, 32'd10};
      ex[0] = sv[0];
      feed(1);
      drain(1);

      // Reset mid-ACCUM
      start_tile(1, 0);
      sv[0] = '{32'd99, 32'd99, 32'd99, 32'd99};
      feed(1);
      chk("pre-rst busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #2;
      chk("rst accum busy", 64'(busy), 64'd0);
      chk("rst accum valid", 64'(out_valid), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      start_tile(0, 0);
      sv[0] = '{32'd5, 32'd6, 32'd7, 32'd8};
      ex[0] = sv[0];
      feed(1);
      drain(1);

      // Reset mid-DRAIN drops out_valid at once
      start_tile(0, 0);
      feed(1);
      tick();
      chk("pre-rst valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #2;
      chk("rst drain valid", 64'(out_valid), 64'd0);
      chk("rst drain busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits at the bottom edge of the systolic array and consumes its per-column psum outputs.
- Column c of the array emits c cycles after column 0. The block de-skews the columns into aligned row vectors.
- It accumulates those vectors over multiple K-passes into a local accumulator bank, then drains the finished tile over a valid/ready stream to the output buffer.

Parameters:
- ARRAY_SIZE, 8, number of array columns (psum lanes)
- PSUM_W, 32, width of each psum lane and of each accumulator lane
- ACC_DEPTH, 16, accumulator bank rows (max tile rows)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; latches tile config and begins a tile
- tile_rows_m1  in  $clog2(ACC_DEPTH)  tile rows minus one
- num_passes_m1  in  8  K-passes minus one
- psum_valid  in  1  high when column 0 of psums_in holds a valid result; column c is valid c cycles later
- psums_in  in  ARRAY_SIZE*PSUM_W  flattened array psums, lane c at bits [c*PSUM_W +: PSUM_W]
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accept
- out_data  out  ARRAY_SIZE*PSUM_W  accumulated row vector
- out_row  out  $clog2(ACC_DEPTH)  row index of out_data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last row is accepted
- err_overrun  out  1  sticky; valid data arrived while not in ACCUM

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; FSM to IDLE.
  - Row pointer, pass counter and de-skew pipes cleared.
  - Accumulator contents need not be cleared: pass 0 overwrites.
- De-skew:
  - Lane c passes through ARRAY_SIZE-1-c register stages.
  - psum_valid is delayed by ARRAY_SIZE-1 stages to form aligned_valid.
  - The aligned vector is therefore available exactly ARRAY_SIZE-1 cycles after psum_valid.
  - The pipe runs in every state.
- FSM states IDLE, ACCUM, DRAIN:
  - IDLE: on start, latch tile_rows_m1 and num_passes_m1, clear row_ptr, pass_cnt and err_overrun, then go to ACCUM. start in any other state is ignored.
  - ACCUM, on each aligned_valid:
    - pass_cnt==0: acc[row_ptr] <= aligned vector; otherwise acc[row_ptr] <= acc[row_ptr] + aligned vector.
    - The add is per lane, modulo 2^PSUM_W (two's-complement wrap, no saturation).
    - row_ptr wraps from tile_rows_m1 to 0 and increments pass_cnt.
    - When row_ptr==tile_rows_m1 and pass_cnt==num_passes_m1, go to DRAIN on the next cycle with drain_ptr=0.
  - DRAIN:
    - out_valid=1, out_data=acc[drain_ptr], out_row=drain_ptr.
    - out_data and out_row hold stable while out_valid && !out_ready.
    - On handshake, drain_ptr increments. On the handshake at drain_ptr==tile_rows_m1, go to IDLE and pulse done the next cycle, with out_valid low.
- aligned_valid in IDLE or DRAIN: data is dropped and err_overrun is set. err_overrun holds until the next accepted start or rst.
- Accumulator writes are single-cycle register-bank updates. The drain reads rows already final, so there is no read/write hazard.
- Reset mid-ACCUM or mid-DRAIN: immediate abort to IDLE; partial results are lost; out_valid drops asynchronously.
- Registered accumulator values feed out_data, with a registered mux allowed. The first out_valid appears 1 cycle after entering DRAIN.

Decomposition:
- Shared package psum_collector_pkg:
  - PSUM_W default constant.
  - FSM state enum (IDLE/ACCUM/DRAIN).
  - lane slice helper function.
- Sub-module psum_deskew (per-lane triangular delay plus the valid delay line), parameterised on ARRAY_SIZE and PSUM_W.

Test Plan:
- Single pass, ARRAY_SIZE=4, tile_rows_m1=0, num_passes_m1=0:
  - Stimulus: psum_valid at t0 with lanes {1,2,3,4}, each lane presented at t0+c.
  - Response: out_valid with out_data={1,2,3,4}, out_row=0; done follows the handshake.
- Three passes, 2 rows:
  - Stimulus: pass p row r lanes all = 10*p+r.
  - Response: row0 = 30, row1 = 33 in every lane; err_overrun=0.
- Wrap arithmetic:
  - Stimulus: pass0 lane0=32'hFFFF_FFFF, pass1 lane0=2.
  - Response: out_data lane0=1.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DRAIN.
  - Response: out_valid stays 1 and out_data/out_row are unchanged; rows emerge in order 0..tile_rows_m1 with none dropped or duplicated.
- Overrun:
  - Stimulus: psum_valid pulse with no start issued.
  - Response: err_overrun=1 after ARRAY_SIZE-1 cycles; the next start clears it.
- Reset mid-ACCUM:
  - Stimulus: assert rst after 1 of 2 rows of pass 0.
  - Response: busy=0 and out_valid=0 immediately; a fresh single-pass tile then produces correct values.
